// File: rtl/miriscv_pkg.sv
// Shared definitions for the register-file writeback path: default widths and
// arbiter state encoding.
package miriscv_pkg;

  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefDataW = 32;

  // Arbiter states, kept as plain constants for compatibility with older blocks.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPend  = 2'd1;
  localparam logic [1:0] StForce = 2'd2;

endpackage

// File: rtl/miriscv_rf_wb_arb_if.sv
// Writeback arbiter bus: two writeback sources, scoreboard control, hazard
// queries and the register-file write port.
interface miriscv_rf_wb_arb_if
  import miriscv_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic              a_we_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_wd_i;

  logic              b_valid_i;
  logic              b_ready_o;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_wd_i;

  logic              sb_set_i;
  logic [ADDR_W-1:0] sb_rd_i;
  logic [ADDR_W-1:0] rs1_i;
  logic [ADDR_W-1:0] rs2_i;
  logic              busy1_o;
  logic              busy2_o;

  logic              stall_o;
  logic              a_lost_o;

  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_wd_o;

  // Arbiter side.
  modport slave (
    input  a_we_i, a_addr_i, a_wd_i,
    input  b_valid_i, b_addr_i, b_wd_i,
    input  sb_set_i, sb_rd_i, rs1_i, rs2_i,
    output b_ready_o, busy1_o, busy2_o, stall_o, a_lost_o,
    output rf_we_o, rf_addr_o, rf_wd_o
  );

  // Pipeline / register-file side.
  modport master (
    output a_we_i, a_addr_i, a_wd_i,
    output b_valid_i, b_addr_i, b_wd_i,
    output sb_set_i, sb_rd_i, rs1_i, rs2_i,
    input  b_ready_o, busy1_o, busy2_o, stall_o, a_lost_o,
    input  rf_we_o, rf_addr_o, rf_wd_o
  );

endinterface

// File: rtl/miriscv_wb_scoreboard.sv
// Busy vector of registers with an outstanding port-B write. Set beats clear
// on the same bit; x0 is never busy.
module miriscv_wb_scoreboard
  import miriscv_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[rs1_i];
  assign busy2_o = busy_q[rs2_i];

endmodule

// File: rtl/miriscv_rf_wb_arb.sv
// Single-write-port register file arbiter: port A (in-order pipe) normally wins,
// port B results wait in a one-entry buffer with starvation-forced drain.
module miriscv_rf_wb_arb
  import miriscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = 4   // legal range 1..15
) (
  input logic                clk_i,
  input logic                reset_n,
  miriscv_rf_wb_arb_if.slave wb
);

  localparam logic [3:0] StarveLast = 4'(STARVE_MAX - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_wd_q;

  logic b_ready;
  logic accept;
  logic buf_full;
  logic a_wr;
  logic younger;
  logic a_sel;
  logic drain;

  // Buffer occupancy is implied by state: PEND and FORCE both hold an entry.
  assign b_ready  = (state_q == StIdle);
  assign buf_full = !b_ready;
  assign accept   = wb.b_valid_i && b_ready;

  assign a_wr    = wb.a_we_i && (wb.a_addr_i != '0);
  // A younger A write to the buffered register makes the buffered value dead.
  assign younger = buf_full && a_wr && (wb.a_addr_i == buf_addr_q);
  assign a_sel   = a_wr && ((state_q != StForce) || younger);
  assign drain   = buf_full && !a_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPend;
          cnt_d   = '0;
        end
      end
      StPend: begin
        if (younger || drain) begin
          state_d = StIdle;
        end else if (cnt_q == StarveLast) begin
          state_d = StForce;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StForce: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      buf_addr_q <= '0;
      buf_wd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        buf_addr_q <= wb.b_addr_i;
        buf_wd_q   <= wb.b_wd_i;
      end
    end
  end

  always_comb begin
    wb.rf_we_o   = 1'b0;
    wb.rf_addr_o = '0;
    wb.rf_wd_o   = '0;
    if (a_sel) begin
      wb.rf_we_o   = 1'b1;
      wb.rf_addr_o = wb.a_addr_i;
      wb.rf_wd_o   = wb.a_wd_i;
    end else if (buf_full) begin
      // A buffered x0 result still drains, it just never reaches the file.
      wb.rf_we_o   = (buf_addr_q != '0);
      wb.rf_addr_o = buf_addr_q;
      wb.rf_wd_o   = buf_wd_q;
    end
  end

  assign wb.b_ready_o = b_ready;
  assign wb.stall_o   = (state_q == StForce);
  assign wb.a_lost_o  = (state_q == StForce) && wb.a_we_i && !younger;

  miriscv_wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .set_i     (wb.sb_set_i),
    .set_addr_i(wb.sb_rd_i),
    .clr_i     (drain || younger),
    .clr_addr_i(buf_addr_q),
    .rs1_i     (wb.rs1_i),
    .rs2_i     (wb.rs2_i),
    .busy1_o   (wb.busy1_o),
    .busy2_o   (wb.busy2_o)
  );

endmodule

// File: tb/tb_miriscv_rf_wb_arb.sv
// Directed bench for the writeback arbiter: reset, port A, buffered port B,
// starvation drain, younger-wins discard and scoreboard set/clear race.
module tb_miriscv_rf_wb_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk_i   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_i = ~clk_i;

  miriscv_rf_wb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) wb_if ();

  miriscv_rf_wb_arb #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(4)
  ) dut (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .wb     (wb_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    wb_if.a_we_i    = 1'b0;
    wb_if.a_addr_i  = '0;
    wb_if.a_wd_i    = '0;
    wb_if.b_valid_i = 1'b0;
    wb_if.b_addr_i  = '0;
    wb_if.b_wd_i    = '0;
    wb_if.sb_set_i  = 1'b0;
    wb_if.sb_rd_i   = '0;
    wb_if.rs1_i     = '0;
    wb_if.rs2_i     = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch_b(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    wb_if.sb_set_i  = 1'b1;
    wb_if.sb_rd_i   = rd;
    wb_if.b_valid_i = 1'b1;
    wb_if.b_addr_i  = rd;
    wb_if.b_wd_i    = wd;
  endtask

  initial begin
    drive_idle();
    wb_if.rs1_i = 5'd5;
    #12;
    check_eq("rst_b_ready", 32'(wb_if.b_ready_o), 32'd1);
    check_eq("rst_stall",   32'(wb_if.stall_o),   32'd0);
    check_eq("rst_a_lost",  32'(wb_if.a_lost_o),  32'd0);
    check_eq("rst_rf_we",   32'(wb_if.rf_we_o),   32'd0);
    check_eq("rst_busy1",   32'(wb_if.busy1_o),   32'd0);
    reset_n = 1'b1;
    next_cycle();

    // Port A only, including the x0 filter.
    wb_if.a_we_i   = 1'b1;
    wb_if.a_addr_i = 5'd3;
    wb_if.a_wd_i   = 32'hDEADBEEF;
    #1;
    check_eq("a_we",   32'(wb_if.rf_we_o),   32'd1);
    check_eq("a_addr", 32'(wb_if.rf_addr_o), 32'd3);
    check_eq("a_wd",   wb_if.rf_wd_o,        32'hDEADBEEF);
    wb_if.a_addr_i = 5'd0;
    #1;
    check_eq("a_x0_we", 32'(wb_if.rf_we_o), 32'd0);
    drive_idle();
    next_cycle();

    // Port B through the idle path.
    wb_if.sb_set_i = 1'b1;
    wb_if.sb_rd_i  = 5'd7;
    next_cycle();
    drive_idle();
    wb_if.b_valid_i = 1'b1;
    wb_if.b_addr_i  = 5'd7;
    wb_if.b_wd_i    = 32'h1234;
    wb_if.rs1_i     = 5'd7;
    #1;
    check_eq("b_busy_set",  32'(wb_if.busy1_o),   32'd1);
    check_eq("b_ready_idle", 32'(wb_if.b_ready_o), 32'd1);
    check_eq("b_cap_no_we", 32'(wb_if.rf_we_o),   32'd0);
    next_cycle();
    wb_if.b_valid_i = 1'b0;
    #1;
    check_eq("b_ready_pend", 32'(wb_if.b_ready_o), 32'd0);
    check_eq("b_we",        32'(wb_if.rf_we_o),   32'd1);
    check_eq("b_addr",      32'(wb_if.rf_addr_o), 32'd7);
    check_eq("b_wd",        wb_if.rf_wd_o,        32'h1234);
    check_eq("b_busy_hold", 32'(wb_if.busy1_o),   32'd1);
    next_cycle();
    #1;
    check_eq("b_busy_clr",  32'(wb_if.busy1_o),   32'd0);
    check_eq("b_ready_back", 32'(wb_if.b_ready_o), 32'd1);
    check_eq("b_we_done",   32'(wb_if.rf_we_o),   32'd0);
    drive_idle();
    next_cycle();

    // Starvation: four blocked cycles, then FORCE drains the buffer.
    launch_b(5'd6, 32'h66);
    next_cycle();
    drive_idle();
    wb_if.a_we_i   = 1'b1;
    wb_if.a_addr_i = 5'd1;
    wb_if.a_wd_i   = 32'h11;
    wb_if.rs2_i    = 5'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("starve_stall", 32'(wb_if.stall_o),   32'd0);
      check_eq("starve_addr",  32'(wb_if.rf_addr_o), 32'd1);
      check_eq("starve_busy",  32'(wb_if.busy2_o),   32'd1);
      next_cycle();
    end
    #1;
    check_eq("force_stall",  32'(wb_if.stall_o),   32'd1);
    check_eq("force_lost",   32'(wb_if.a_lost_o),  32'd1);
    check_eq("force_we",     32'(wb_if.rf_we_o),   32'd1);
    check_eq("force_addr",   32'(wb_if.rf_addr_o), 32'd6);
    check_eq("force_wd",     wb_if.rf_wd_o,        32'h66);
    check_eq("force_bready", 32'(wb_if.b_ready_o), 32'd0);
    next_cycle();
    #1;
    check_eq("post_force_stall", 32'(wb_if.stall_o),   32'd0);
    check_eq("post_force_lost",  32'(wb_if.a_lost_o),  32'd0);
    check_eq("post_force_addr",  32'(wb_if.rf_addr_o), 32'd1);
    check_eq("post_force_busy",  32'(wb_if.busy2_o),   32'd0);
    check_eq("post_force_ready", 32'(wb_if.b_ready_o), 32'd1);
    drive_idle();
    next_cycle();

    // Younger A write to the buffered register discards the entry.
    launch_b(5'd9, 32'h1);
    next_cycle();
    drive_idle();
    wb_if.a_we_i   = 1'b1;
    wb_if.a_addr_i = 5'd9;
    wb_if.a_wd_i   = 32'h2;
    wb_if.rs1_i    = 5'd9;
    #1;
    check_eq("young_we",   32'(wb_if.rf_we_o),   32'd1);
    check_eq("young_addr", 32'(wb_if.rf_addr_o), 32'd9);
    check_eq("young_wd",   wb_if.rf_wd_o,        32'h2);
    check_eq("young_lost", 32'(wb_if.a_lost_o),  32'd0);
    check_eq("young_busy", 32'(wb_if.busy1_o),   32'd1);
    next_cycle();
    drive_idle();
    wb_if.rs1_i = 5'd9;
    #1;
    check_eq("young_idle",  32'(wb_if.b_ready_o), 32'd1);
    check_eq("young_clr",   32'(wb_if.busy1_o),   32'd0);
    check_eq("young_no_we", 32'(wb_if.rf_we_o),   32'd0);
    check_eq("young_stall", 32'(wb_if.stall_o),   32'd0);
    next_cycle();

    // Scoreboard race: re-issue to x4 on the edge that drains x4.
    launch_b(5'd4, 32'h44);
    next_cycle();
    drive_idle();
    wb_if.sb_set_i = 1'b1;
    wb_if.sb_rd_i  = 5'd4;
    wb_if.rs2_i    = 5'd4;
    #1;
    check_eq("race_we",   32'(wb_if.rf_we_o),   32'd1);
    check_eq("race_addr", 32'(wb_if.rf_addr_o), 32'd4);
    next_cycle();
    wb_if.sb_set_i = 1'b0;
    #1;
    check_eq("race_busy",  32'(wb_if.busy2_o),   32'd1);
    check_eq("race_ready", 32'(wb_if.b_ready_o), 32'd1);
    next_cycle();

    // Reset while PEND holds x5.
    launch_b(5'd5, 32'h55);
    next_cycle();
    drive_idle();
    wb_if.a_we_i   = 1'b1;
    wb_if.a_addr_i = 5'd2;
    wb_if.a_wd_i   = 32'h22;
    wb_if.rs1_i    = 5'd5;
    wb_if.rs2_i    = 5'd4;
    #1;
    check_eq("pre_rst_ready", 32'(wb_if.b_ready_o), 32'd0);
    check_eq("pre_rst_busy",  32'(wb_if.busy1_o),   32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(wb_if.b_ready_o), 32'd1);
    check_eq("mid_rst_stall", 32'(wb_if.stall_o),   32'd0);
    check_eq("mid_rst_busy5", 32'(wb_if.busy1_o),   32'd0);
    check_eq("mid_rst_busy4", 32'(wb_if.busy2_o),   32'd0);
    wb_if.a_we_i = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(wb_if.rf_we_o), 32'd0);
    reset_n = 1'b1;
    next_cycle();
    #1;
    check_eq("post_rst_we",    32'(wb_if.rf_we_o),   32'd0);
    check_eq("post_rst_ready", 32'(wb_if.b_ready_o), 32'd1);
    next_cycle();
    #1;
    check_eq("post_rst_we2", 32'(wb_if.rf_we_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/miriscv_rf_wb_arb.md
Name: miriscv_rf_wb_arb

Overview:
- Write-port arbiter and scoreboard for the single-write-port register file (`rf_*` outputs drive its `we`/`addr3`/`wd` inputs).
- Merges two writeback sources:
  - Port A: the in-order pipeline, single-cycle, never back-pressured.
  - Port B: the LSU/multi-cycle unit, valid/ready handshake.
- Port B results wait in a one-entry buffer until the write port is free.
- Tracks which registers have an outstanding port-B write, so issue logic can stall on RAW and WAW hazards.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive blocked cycles before a forced drain; legal range 1..15.

Ports:
- clk_i  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- a_we_i  in  1  port A write request.
- a_addr_i  in  ADDR_W  port A destination.
- a_wd_i  in  DATA_W  port A data.
- b_valid_i  in  1  port B result valid.
- b_ready_o  out  1  port B buffer can accept.
- b_addr_i  in  ADDR_W  port B destination.
- b_wd_i  in  DATA_W  port B data.
- sb_set_i  in  1  issue stage launched a port-B op.
- sb_rd_i  in  ADDR_W  destination of that op.
- rs1_i  in  ADDR_W  hazard query address 1.
- rs2_i  in  ADDR_W  hazard query address 2.
- busy1_o  out  1  rs1_i has a pending port-B write.
- busy2_o  out  1  rs2_i has a pending port-B write.
- stall_o  out  1  request that the pipeline hold port A idle.
- a_lost_o  out  1  one-cycle pulse: port A write dropped in FORCE.
- rf_we_o  out  1  register file write enable.
- rf_addr_o  out  ADDR_W  register file write address.
- rf_wd_o  out  DATA_W  register file write data.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; buffer empty; starve counter 0; scoreboard all 0.
  - Outputs: b_ready_o=1, stall_o=0, a_lost_o=0, rf_we_o=0, busy1_o=busy2_o=0.
  - Reset mid-operation discards any buffered result.
- x0: a write with addr 0 never asserts rf_we_o. Scoreboard bit 0 is hardwired to 0.
- Port B accept:
  - Handshake completes when b_valid_i && b_ready_o at a clock edge; data and address are captured into the buffer.
  - b_ready_o = (state==IDLE), decoded directly from registered state, no combinational path from inputs.
  - A captured result cannot be written in its capture cycle; minimum capture-to-write latency is 1 cycle.
- RF outputs are combinational, so the write lands at the next edge.
  - A selected: rf_* = A when a_we_i && a_addr_i!=0 and state!=FORCE.
  - Else, buffer full: rf_* = buffer, and the buffer drains this cycle.
  - Else: rf_we_o=0. rf_addr_o and rf_wd_o are don't-care but held at 0.
- State machine:
  - IDLE: on accept -> PEND, counter cleared.
  - PEND, A not writing: buffer drains -> IDLE.
  - PEND, A writing: counter increments; when counter reaches STARVE_MAX-1 while blocked -> FORCE.
  - FORCE: stall_o=1, registered, asserted for the whole state. Buffer has priority and drains -> IDLE. If a_we_i=1 in FORCE, the A write is dropped and a_lost_o pulses.
- Younger-wins rule: in PEND/FORCE, if A writes the same nonzero address held in the buffer:
  - A write proceeds and the buffer entry is discarded.
  - Busy bit is cleared; next state is IDLE.
  - The edge that discards the entry does not count as starvation.
- Scoreboard:
  - A bit is set at the edge where sb_set_i=1 (sb_rd_i!=0).
  - A bit is cleared at the edge where the buffer drains or is discarded, for that address.
  - Simultaneous set and clear of the same bit: set wins.
  - busy1_o/busy2_o = bit[rs1_i] / bit[rs2_i], combinational.
- Widths: the counter is 4 bits, with no wrap because it saturates at the FORCE transition.

Decomposition:
- Shared package miriscv_pkg:
  - ADDR_W and DATA_W defaults.
  - Arbiter state encoding: IDLE=2'd0, PEND=2'd1, FORCE=2'd2.
- Sub-module miriscv_wb_scoreboard: 32-bit busy vector with set/clear ports and two read ports.
- The arbiter FSM and buffer stay in the top module.

Test Plan:
- Reset: reset_n low mid-PEND with the buffer holding x5 -> b_ready_o=1, stall_o=0, busy(x5)=0 immediately; no rf_we_o after release.
- A only: a_we_i=1, addr 3, data 0xDEADBEEF -> rf_we_o=1, addr 3, data 0xDEADBEEF in the same cycle. addr 0 -> rf_we_o=0.
- B idle path: sb_set x7, then B valid, x7 = 0x1234 with A idle -> captured at edge N; rf_we_o=1, addr 7 in cycle N+1; busy(x7) 1 until the edge ending N+1, then 0.
- Starvation: B in buffer, A writes continuously with STARVE_MAX=4 -> buffer drains only after stall_o has risen. An A write presented during FORCE gives a_lost_o=1 and rf_addr_o = the buffer address.
- Younger wins: buffer holds x9 = 0x1, A writes x9 = 0x2 -> RF gets 0x2 only, state IDLE next, busy(x9)=0.
- Scoreboard race: sb_set x4 in the same cycle the buffer drains x4 -> busy(x4)=1 afterward.
